// File: rtl/dbpsk_demodulator_if.sv
// Receive enable, line input and decoded-bit outputs of the DBPSK demodulator.
// The demodulator uses the slave view; whatever drives the line and consumes bits uses master.
interface dbpsk_demodulator_if #(
  parameter int BIT_CNT_WIDTH = 8
);
  logic                     trigger;
  logic                     input_dbpsk;
  logic                     output_data;
  logic                     output_valid;
  logic                     frame_done;
  logic [BIT_CNT_WIDTH-1:0] bit_count;

  modport master (
    output trigger,
    output input_dbpsk,
    input  output_data,
    input  output_valid,
    input  frame_done,
    input  bit_count
  );

  modport slave (
    input  trigger,
    input  input_dbpsk,
    output output_data,
    output output_valid,
    output frame_done,
    output bit_count
  );
endinterface

// File: rtl/dbpsk_demodulator.sv
// DBPSK receiver: synchronizes the line, locks on a start toggle, majority-votes each symbol
// and emits one differentially decoded bit per symbol plus a frame-done strobe.
module dbpsk_demodulator #(
  parameter int SYMBOL_CYCLES = 50,
  parameter int CNT_WIDTH     = 16,
  parameter int FRAME_BITS    = 8,
  parameter int BIT_CNT_WIDTH = 8
) (
  input  logic               clock,
  input  logic               reset,
  dbpsk_demodulator_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    HUNT,
    TRACK
  } state_t;

  localparam logic [CNT_WIDTH-1:0]     LAST_SAMPLE = CNT_WIDTH'(SYMBOL_CYCLES - 1);
  localparam logic [CNT_WIDTH:0]       SYMBOL_LEN  = (CNT_WIDTH + 1)'(SYMBOL_CYCLES);
  localparam logic [BIT_CNT_WIDTH-1:0] LAST_BIT    = BIT_CNT_WIDTH'(FRAME_BITS);

  state_t                   state, state_n;
  logic                     sync_meta, sync_in, sync_d, in_edge;
  logic [CNT_WIDTH-1:0]     counter, counter_n;
  logic [CNT_WIDTH-1:0]     ones, ones_n, total;
  logic [CNT_WIDTH:0]       twice_total;
  logic                     prev_level, prev_level_n;
  logic                     first_sym, first_sym_n;
  logic                     level;
  logic [BIT_CNT_WIDTH-1:0] bit_count, bit_count_n, bit_count_inc;
  logic                     data_q, data_n;
  logic                     valid_q, valid_n;
  logic                     done_q, done_n;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_meta <= 1'b0;
      sync_in   <= 1'b0;
      sync_d    <= 1'b0;
    end else begin
      sync_meta <= bus.input_dbpsk;
      sync_in   <= sync_meta;
      sync_d    <= sync_in;
    end
  end

  assign in_edge       = sync_in ^ sync_d;
  assign total         = ones + CNT_WIDTH'(sync_in);
  assign twice_total   = {total, 1'b0};
  assign bit_count_inc = bit_count + BIT_CNT_WIDTH'(1);

  // An exact tie keeps the previous level, so a balanced symbol decodes as 0.
  always_comb begin
    if (twice_total > SYMBOL_LEN) begin
      level = 1'b1;
    end else if (twice_total < SYMBOL_LEN) begin
      level = 1'b0;
    end else begin
      level = prev_level;
    end
  end

  always_comb begin
    state_n      = state;
    counter_n    = counter;
    ones_n       = ones;
    prev_level_n = prev_level;
    first_sym_n  = first_sym;
    bit_count_n  = bit_count;
    data_n       = data_q;
    valid_n      = 1'b0;
    done_n       = 1'b0;

    case (state)
      IDLE: begin
        counter_n    = '0;
        ones_n       = '0;
        prev_level_n = 1'b0;
        first_sym_n  = 1'b0;
        bit_count_n  = '0;
        data_n       = 1'b0;
        state_n      = HUNT;
      end
      HUNT: begin
        bit_count_n = '0;
        if (in_edge) begin
          counter_n   = CNT_WIDTH'(1);
          ones_n      = CNT_WIDTH'(sync_in);
          first_sym_n = 1'b1;
          state_n     = TRACK;
        end
      end
      TRACK: begin
        if (counter == LAST_SAMPLE) begin
          counter_n    = '0;
          ones_n       = '0;
          prev_level_n = level;
          if (first_sym) begin
            first_sym_n = 1'b0;
          end else begin
            data_n      = level ^ prev_level;
            valid_n     = 1'b1;
            bit_count_n = bit_count_inc;
            if (bit_count_inc == LAST_BIT) begin
              done_n  = 1'b1;
              state_n = HUNT;
            end
          end
        end else begin
          counter_n = counter + CNT_WIDTH'(1);
          ones_n    = total;
        end
      end
      default: state_n = IDLE;
    endcase

    // Dropping the enable abandons the frame, including a decision made this cycle.
    if (!bus.trigger) begin
      state_n      = IDLE;
      counter_n    = '0;
      ones_n       = '0;
      prev_level_n = 1'b0;
      first_sym_n  = 1'b0;
      bit_count_n  = '0;
      data_n       = 1'b0;
      valid_n      = 1'b0;
      done_n       = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      counter    <= '0;
      ones       <= '0;
      prev_level <= 1'b0;
      first_sym  <= 1'b0;
      bit_count  <= '0;
      data_q     <= 1'b0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state      <= state_n;
      counter    <= counter_n;
      ones       <= ones_n;
      prev_level <= prev_level_n;
      first_sym  <= first_sym_n;
      bit_count  <= bit_count_n;
      data_q     <= data_n;
      valid_q    <= valid_n;
      done_q     <= done_n;
    end
  end

  assign bus.output_data  = data_q;
  assign bus.output_valid = valid_q;
  assign bus.frame_done   = done_q;
  assign bus.bit_count    = bit_count;
endmodule

// File: tb/tb_dbpsk_demodulator.sv
// Bench for dbpsk_demodulator: drives DBPSK symbols, predicts decoded bits from majority/toggle
// rules and checks every cycle's outputs against that prediction.
module tb_dbpsk_demodulator;
  localparam int SYMBOL_CYCLES = 50;
  localparam int FRAME_BITS    = 8;
  localparam int BIT_CNT_WIDTH = 8;

  logic clock = 1'b0;
  logic reset;

  dbpsk_demodulator_if #(.BIT_CNT_WIDTH(BIT_CNT_WIDTH)) dif ();

  dbpsk_demodulator #(
    .SYMBOL_CYCLES(SYMBOL_CYCLES),
    .CNT_WIDTH    (16),
    .FRAME_BITS   (FRAME_BITS),
    .BIT_CNT_WIDTH(BIT_CNT_WIDTH)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (dif)
  );

  always #5 clock = ~clock;

  int          checks = 0;
  int          errors = 0;
  bit          expQueue[$];
  logic        lineLevel = 1'b0;
  logic        modelPrev = 1'b0;
  logic        modelFirst = 1'b1;
  int          strobeCount = 0;
  int          doneCount = 0;
  logic [15:0] capBits = '0;
  int          expIndex = 0;
  logic        expData = 1'b0;
  int          cycle = 0;
  int          lastStrobeCycle = 0;
  logic        trigPrev = 1'b0;
  logic        resetPrev = 1'b0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  // Drives one symbol (level lvl, inverted for gLen samples from gStart) and predicts its bit.
  task automatic applyStimulus(input logic lvl, input int gStart, input int gLen);
    int   ones = 0;
    logic v;
    logic decided;
    for (int i = 0; i < SYMBOL_CYCLES; i++) begin
      v = (i >= gStart && i < gStart + gLen) ? ~lvl : lvl;
      dif.input_dbpsk = v;
      lineLevel = v;
      if (v) ones++;
      @(posedge clock);
      #2;
    end
    if (2 * ones > SYMBOL_CYCLES) decided = 1'b1;
    else if (2 * ones < SYMBOL_CYCLES) decided = 1'b0;
    else decided = modelPrev;
    if (!modelFirst) expQueue.push_back(decided ^ modelPrev);
    modelPrev  = decided;
    modelFirst = 1'b0;
  endtask

  task automatic sendFrame(input logic [7:0] bits, input int nBits, input int glitchBit);
    modelFirst = 1'b1;
    applyStimulus(~lineLevel, 0, 0);
    for (int k = 0; k < nBits; k++) begin
      if (k == glitchBit) applyStimulus(lineLevel ^ bits[7-k], 15, 20);
      else applyStimulus(lineLevel ^ bits[7-k], 0, 0);
    end
  endtask

  task automatic waitDrain();
    int n = 0;
    while (expQueue.size() != 0 && n < 10) begin
      @(posedge clock);
      #2;
      n++;
    end
    checkOutput("drain_pending_bits", expQueue.size(), 0);
  endtask

  // Per-cycle compare against the predicted bit stream, sampled mid-cycle.
  always @(negedge clock) begin
    cycle++;
    if (!reset || !trigPrev || !resetPrev) begin
      checkOutput("idle_valid", int'(dif.output_valid), 0);
      checkOutput("idle_data", int'(dif.output_data), 0);
      checkOutput("idle_done", int'(dif.frame_done), 0);
      checkOutput("idle_bit_count", int'(dif.bit_count), 0);
      if (expQueue.size() != 0) begin
        checkOutput("lost_bits", expQueue.size(), 0);
        expQueue.delete();
      end
      expIndex = 0;
      expData  = 1'b0;
    end else if (dif.output_valid) begin
      strobeCount++;
      capBits = {capBits[14:0], dif.output_data};
      if (dif.frame_done) doneCount++;
      if (expQueue.size() == 0) begin
        checkOutput("unexpected_strobe", int'(dif.output_valid), 0);
      end else begin
        expData = expQueue.pop_front();
        expIndex++;
        checkOutput("bit_value", int'(dif.output_data), int'(expData));
        checkOutput("bit_count", int'(dif.bit_count), expIndex);
        checkOutput("frame_done", int'(dif.frame_done), (expIndex == FRAME_BITS) ? 1 : 0);
        if (expIndex > 1) checkOutput("strobe_spacing", cycle - lastStrobeCycle, SYMBOL_CYCLES);
        lastStrobeCycle = cycle;
        if (expIndex == FRAME_BITS) expIndex = 0;
      end
    end else begin
      checkOutput("hold_data", int'(dif.output_data), int'(expData));
      checkOutput("hold_bit_count", int'(dif.bit_count), expIndex);
      checkOutput("quiet_done", int'(dif.frame_done), 0);
    end
    trigPrev  = dif.trigger;
    resetPrev = reset;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int s0;
    int d0;
    dif.trigger     = 1'b0;
    dif.input_dbpsk = 1'b0;
    reset           = 1'b1;
    #1 reset = 1'b0;
    #1;
    checkOutput("reset_valid", int'(dif.output_valid), 0);
    checkOutput("reset_data", int'(dif.output_data), 0);
    checkOutput("reset_done", int'(dif.frame_done), 0);
    checkOutput("reset_bit_count", int'(dif.bit_count), 0);
    #21 reset = 1'b1;
    @(posedge clock);
    #2;
    dif.trigger = 1'b1;
    waitCycles(4);

    $display("[TB] loopback frame 1,0,1,1,0,0,1,0");
    sendFrame(8'b10110010, 8, -1);
    waitDrain();
    checkOutput("loopback_bits", int'(capBits[7:0]), 'hB2);
    checkOutput("loopback_strobes", strobeCount, 8);
    checkOutput("loopback_done", doneCount, 1);

    $display("[TB] glitch in bit 3");
    waitCycles(5);
    sendFrame(8'b10110010, 8, 2);
    waitDrain();
    checkOutput("glitch_bits", int'(capBits[7:0]), 'hB2);
    checkOutput("glitch_done", doneCount, 2);

    $display("[TB] tie symbol");
    waitCycles(5);
    modelFirst = 1'b1;
    applyStimulus(~lineLevel, 0, 0);
    applyStimulus(lineLevel, 25, 25);
    applyStimulus(lineLevel, 0, 0);
    waitDrain();
    checkOutput("tie_bits", int'(capBits[1:0]), 1);
    dif.trigger = 1'b0;
    waitCycles(3);
    dif.trigger = 1'b1;
    waitCycles(3);

    $display("[TB] abort after bit 4");
    sendFrame(8'b10110010, 4, -1);
    waitCycles(4);
    checkOutput("abort_bits_before", int'(capBits[3:0]), 'hB);
    checkOutput("abort_count_before", int'(dif.bit_count), 4);
    s0 = strobeCount;
    dif.trigger = 1'b0;
    @(posedge clock);
    #1;
    checkOutput("abort_valid", int'(dif.output_valid), 0);
    checkOutput("abort_data", int'(dif.output_data), 0);
    checkOutput("abort_done", int'(dif.frame_done), 0);
    checkOutput("abort_bit_count", int'(dif.bit_count), 0);
    #1;
    waitCycles(60);
    checkOutput("abort_no_strobe", strobeCount, s0);
    checkOutput("abort_no_done", doneCount, 2);
    dif.trigger = 1'b1;
    waitCycles(3);
    sendFrame(8'b10110010, 8, -1);
    waitDrain();
    checkOutput("resend_bits", int'(capBits[7:0]), 'hB2);
    checkOutput("resend_done", doneCount, 3);

    $display("[TB] back-to-back frames");
    s0 = strobeCount;
    d0 = doneCount;
    sendFrame(8'b10110010, 8, -1);
    waitCycles(7);
    sendFrame(8'b01100111, 8, -1);
    waitDrain();
    checkOutput("b2b_strobes", strobeCount - s0, 16);
    checkOutput("b2b_done", doneCount - d0, 2);
    checkOutput("b2b_bits", int'(capBits), 'hB267);

    $display("[TB] async reset mid-symbol");
    dif.trigger     = 1'b0;
    dif.input_dbpsk = 1'b0;
    lineLevel       = 1'b0;
    waitCycles(3);
    dif.trigger = 1'b1;
    waitCycles(3);
    modelFirst = 1'b1;
    applyStimulus(1'b1, 0, 0);
    applyStimulus(1'b0, 0, 0);
    waitCycles(20);
    checkOutput("pre_reset_bit_count", int'(dif.bit_count), 1);
    #1 reset = 1'b0;
    #1;
    checkOutput("areset_valid", int'(dif.output_valid), 0);
    checkOutput("areset_data", int'(dif.output_data), 0);
    checkOutput("areset_done", int'(dif.frame_done), 0);
    checkOutput("areset_bit_count", int'(dif.bit_count), 0);
    #28 reset = 1'b1;
    s0 = strobeCount;
    waitCycles(60);
    checkOutput("areset_no_strobe", strobeCount, s0);
    d0 = doneCount;
    sendFrame(8'b10110010, 8, -1);
    waitDrain();
    checkOutput("post_reset_bits", int'(capBits[7:0]), 'hB2);
    checkOutput("post_reset_done", doneCount - d0, 1);

    waitCycles(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dbpsk_demodulator.md
# dbpsk_demodulator

Receive-side counterpart of the DBPSK modulator. Recovers data bits from a differentially phase-encoded 1-bit square wave, where a level toggle at a symbol boundary means '1' and no toggle means '0'. It synchronizes the input, locks onto a mandatory start toggle, and integrates each symbol by majority vote. It emits one bit per symbol with a valid strobe, and a frame-done strobe after a fixed number of bits. It sits on the backscatter receive/loopback path and is clocked with the modulator so that symbol lengths match.

## Interface
- SYMBOL_CYCLES, 50: clocks per symbol; must match the modulator; ≥ 4.
- CNT_WIDTH, 16: width of the symbol and sample counters.
- FRAME_BITS, 8: data bits per frame, excluding the start symbol; ≥ 1.
- BIT_CNT_WIDTH, 8: width of bit_count; must hold FRAME_BITS.
- clock, input, 1: sole clock, rising edge.
- reset, input, 1: asynchronous, active-low reset.
- trigger, input, 1: receive enable; low forces the idle state.
- input_dbpsk, input, 1: received DBPSK level, asynchronous to clock.
- output_data, output, 1: recovered bit; valid only when output_valid = 1.
- output_valid, output, 1: one-cycle strobe per recovered bit.
- frame_done, output, 1: one-cycle strobe, coincident with the valid of the last frame bit.
- bit_count, output, BIT_CNT_WIDTH: bits emitted in the current frame.

## Operation
- Input conditioning:
  - A 2-flop synchronizer produces sync_in.
  - sync_d is sync_in delayed by one cycle.
  - edge = sync_in XOR sync_d.
- States: IDLE, HUNT, TRACK.
- IDLE (entered when trigger = 0, from any state):
  - Clears the counter, ones, prev_level, first_sym, bit_count, output_data, output_valid and frame_done.
  - On trigger = 1, moves to HUNT on the next clock.
- HUNT:
  - Waits for edge. The first toggle is the start symbol.
  - On edge: counter ← 1, ones ← sync_in, first_sym ← 1, then TRACK.
- TRACK, every cycle:
  - The counter increments and ones accumulates sync_in.
  - At counter = SYMBOL_CYCLES−1, the symbol is decided with total = ones + sync_in (the current sample is included):
    - 2·total > SYMBOL_CYCLES: level = 1.
    - 2·total < SYMBOL_CYCLES: level = 0.
    - Tie: level = prev_level, so the bit is 0.
  - After the decision, the counter and ones return to 0. Every symbol therefore integrates exactly SYMBOL_CYCLES samples.
  - If first_sym = 1: prev_level ← level and first_sym ← 0. Nothing is emitted.
  - Otherwise:
    - output_data ← level XOR prev_level, output_valid ← 1, prev_level ← level, bit_count ← bit_count + 1.
    - If bit_count + 1 = FRAME_BITS: frame_done ← 1, state ← HUNT, and bit_count is cleared on the following cycle.
- In TRACK, edges do not resync the counter. Timing is free-running from the start edge.
- HUNT after a frame waits for the next start toggle. Line level is irrelevant because only edges count.
- output_data holds its value between strobes.
- The ones counter is CNT_WIDTH bits and never exceeds SYMBOL_CYCLES.

## Timing
- Reset values: output_data = 0, output_valid = 0, frame_done = 0, bit_count = 0, state = IDLE.
- Reset takes effect asynchronously.
- Sync latency: a change on input_dbpsk appears as edge 2–3 clocks later.
- A bit is decided in the clock at the end of its symbol, and output_valid rises on the next edge.
- Latency from the modulator toggle to output_valid is SYMBOL_CYCLES + 3 clocks ±1 of sync uncertainty.
- output_valid and frame_done are high for exactly one clock.
- Strobes are SYMBOL_CYCLES clocks apart within a frame.
- If trigger falls mid-frame:
  - The next clock enters IDLE and all outputs clear.
  - No frame_done and no partial bit are produced.
  - A strobe already registered in that cycle is cleared with the rest.
- If trigger falls in the same cycle as a decision, IDLE wins and no strobe is emitted.
- If reset is asserted mid-frame, the block returns to the reset values immediately, and it does not emit until a new start toggle after trigger.

## Test plan
- Loopback, SYMBOL_CYCLES = 50, FRAME_BITS = 8: modulator sends a start '1' then 1,0,1,1,0,0,1,0.
  - Required: eight valid strobes 50 clocks apart with output_data = 1,0,1,1,0,0,1,0.
  - bit_count steps 1..8, and frame_done rises with the 8th strobe.
- Glitch immunity: invert input_dbpsk for 20 cycles in the middle of bit 3 of the frame above. Decoded bits are unchanged.
- Tie: drive the symbol after the start at exactly 25 high and 25 low samples. Output bit = 0 and prev_level is unchanged.
- Abort: drop trigger after bit 4.
  - All outputs are 0 on the next clock, and frame_done is never asserted.
  - Re-raising trigger and resending the frame decodes it fully.
- Back-to-back frames: send two 8-bit frames, each with its own start toggle.
  - Required: 16 strobes total and two frame_done pulses.
  - The HUNT gap between frames produces no strobes.
- Async reset mid-symbol (reset low for 3 cycles, asynchronous to clock):
  - Outputs are 0 immediately.
  - No strobe appears until a new start toggle and a full symbol have passed.
